// File: rtl/sw_debounce_if.sv
// Switch-conditioner signal bundle: raw switch levels in, debounced levels and pulses out.
// TGL exists only when SW_DEBOUNCE_TOGGLE_EN is defined.
interface sw_debounce_if #(
   parameter int unsigned N = 2
);

   logic [N-1:0] SW;
   logic [N-1:0] LV;
   logic [N-1:0] PRESS;
   logic [N-1:0] RELEASE;
   logic         L;
`ifdef SW_DEBOUNCE_TOGGLE_EN
   logic [N-1:0] TGL;
`endif

   // Board / stimulus side
   modport master (
      output SW,
      input  LV,
      input  PRESS,
      input  RELEASE,
`ifdef SW_DEBOUNCE_TOGGLE_EN
      input  TGL,
`endif
      input  L
   );

   // Conditioner side
   modport slave (
      input  SW,
      output LV,
      output PRESS,
      output RELEASE,
`ifdef SW_DEBOUNCE_TOGGLE_EN
      output TGL,
`endif
      output L
   );

endinterface

// File: rtl/sw_debounce.sv
// Per-channel synchroniser plus saturating stability counter for bouncing switches.
// Define SW_DEBOUNCE_TOGGLE_EN to add the registered push-on/push-off TGL output.
module sw_debounce #(
   parameter int unsigned N           = 2,
   parameter int unsigned DB_CYCLES   = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic         CLK,
   input  logic         RSTN,
   sw_debounce_if.slave bus
);

   localparam int unsigned CntW = $clog2(DB_CYCLES + 1);
   // Count value whose increment completes the stability window
   localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0][N-1:0] sync_q, sync_d;
   logic [N-1:0][CntW-1:0]        cnt_q, cnt_d;
   logic [N-1:0]                  lv_q, lv_d;
   logic [N-1:0]                  press_q, press_d;
   logic [N-1:0]                  release_q, release_d;
   logic                          l_q, l_d;
   logic [N-1:0]                  s;

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d[0] = bus.SW;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   always_comb begin
      cnt_d     = cnt_q;
      lv_d      = lv_q;
      press_d   = '0;
      release_d = '0;
      for (int i = 0; i < N; i++) begin
         if (s[i] == lv_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] >= CntLast) begin
            lv_d[i]      = s[i];
            cnt_d[i]     = '0;
            press_d[i]   = s[i];
            release_d[i] = ~s[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
         end
      end
      l_d = &lv_d;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         sync_q    <= '0;
         cnt_q     <= '0;
         lv_q      <= '0;
         press_q   <= '0;
         release_q <= '0;
         l_q       <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         lv_q      <= lv_d;
         press_q   <= press_d;
         release_q <= release_d;
         l_q       <= l_d;
      end
   end

   assign bus.LV      = lv_q;
   assign bus.PRESS   = press_q;
   assign bus.RELEASE = release_q;
   assign bus.L       = l_q;

`ifdef SW_DEBOUNCE_TOGGLE_EN
   logic [N-1:0] tgl_q, tgl_d;

   // Flips on the same edge that raises PRESS
   assign tgl_d = tgl_q ^ press_d;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         tgl_q <= '0;
      end else begin
         tgl_q <= tgl_d;
      end
   end

   assign bus.TGL = tgl_q;
`endif

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
Input-side conditioner for the board's slide/push switches. Synchronises raw SW levels into the CLK domain and filters contact bounce. Presents clean levels, one-cycle press/release pulses and the debounced AND of all channels on L. Sits between the board pins and the gate-level exercise logic, so that logic sees glitch-free inputs.

Parameters:
N, 2, number of switch channels
DB_CYCLES, 16, consecutive stable cycles required to accept a new level (>=2)
SYNC_STAGES, 2, synchroniser flip-flop depth (>=2)

Ports:
CLK  input  1  system clock, all state on rising edge
RSTN  input  1  asynchronous active-low reset
SW  input  N  raw, asynchronous, bouncing switch levels
LV  output  N  debounced switch levels
PRESS  output  N  one-cycle pulse per channel on accepted 0->1
RELEASE  output  N  one-cycle pulse per channel on accepted 1->0
L  output  1  AND of all LV bits (registered with LV)

Behaviour:
- One clock; reset is asynchronous and active-low (CLK, RSTN). The polarity and synchronicity are fixed.
- Reset (RSTN=0, any time, including mid-count): all synchroniser flops=0, counters=0, LV=0, PRESS=0, RELEASE=0, L=0. Release of RSTN is applied synchronously to CLK by the integrator. The block needs no internal reset synchroniser.
- Per channel: SYNC_STAGES-deep FF chain. The last stage is S.
- Counter width: clog2(DB_CYCLES+1). Counter saturates and never wraps.
- At each edge:
  - If S==LV, the counter clears.
  - If S!=LV, the counter increments.
  - When the increment would reach DB_CYCLES: LV<=S, the counter clears, and PRESS (if S=1) or RELEASE (if S=0) goes high for exactly that cycle.
- Latency: a clean SW change is sampled first at edge 1. LV, L and the pulse update at edge SYNC_STAGES+DB_CYCLES (18 with defaults).
- Glitch rejection: any return of S to LV before DB_CYCLES consecutive differing edges clears the counter. LV does not change and no pulse is issued.
- PRESS and RELEASE are mutually exclusive per channel. At most one pulse per accepted transition. No pulse while held.
- Channels are fully independent. Simultaneous acceptance on several channels yields simultaneous pulses. L follows the new LV in the same cycle.
- Outputs are all registered. There are no combinational paths from SW to any output.
- SW held constant: outputs are stable indefinitely, and the counter stays 0.

Optional Feature:
SW_DEBOUNCE_TOGGLE_EN
- Defined: adds output TGL [N], reset 0. TGL[i] inverts on the edge where PRESS[i] is asserted, giving a registered push-on/push-off level per channel.
- Undefined: TGL port and logic are absent. All other behaviour is identical.

Test Plan:
- Reset: assert RSTN=0 mid-count with SW=2'b11 → LV=0, L=0, no pulses. After release and a stable SW=11, LV=11 at edge 18 and L=1.
- Clean press: SW0 0→1 held (10 ns clock) → LV[0]=1 and PRESS[0]=1 for exactly one cycle at edge 18; PRESS[0]=0 at edge 19.
- Bounce: SW1 toggles 1/0 every 30 ns for 300 ns then settles at 1 → one PRESS[1] pulse only, 18 edges after the final settle; no RELEASE[1] pulse.
- Glitch: SW0=1 for 10 cycles then back to 0 → LV[0] stays 0, no pulses, counter returns to 0.
- Release, simultaneous: LV=11, then SW 11→00 at the same time → RELEASE=2'b11 on one cycle; L goes 1→0 on the same edge.
- With SW_DEBOUNCE_TOGGLE_EN: three accepted presses of SW0 → TGL[0] sequence 0→1→0→1, each change coincident with PRESS[0].
